// File: rtl/pipe_ctrl_gen_if.sv
// Pipeline-control bus: stall requests and redirects in, stall/flush/status out.
interface pipe_ctrl_gen_if #(
  parameter int STAGES = 6,
  parameter int NREQ   = 4,
  parameter int CNT_W  = 32
);
  logic [NREQ-1:0]   stall_req;
  logic              excp_req;
  logic [31:0]       excp_pc;
  logic              wdog_clr;
  logic              perf_clr;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              stall_timeout;
  logic [CNT_W-1:0]  stall_cnt;

  // Pipeline side: raises requests, consumes stall/flush.
  modport master (
    output stall_req, excp_req, excp_pc, wdog_clr, perf_clr,
    input  stall, flush, new_pc, stall_timeout, stall_cnt
  );

  // Controller side.
  modport slave (
    input  stall_req, excp_req, excp_pc, wdog_clr, perf_clr,
    output stall, flush, new_pc, stall_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control: merges masked stall requests, sequences redirect flushes,
// watches for stuck stalls and counts stalled cycles.

// One requester's contribution to the stall vector.
module pipe_ctrl_req_mask #(
  parameter int                STAGES = 6,
  parameter logic [STAGES-1:0] MASK   = '0
) (
  input  logic              req,
  output logic [STAGES-1:0] term
);
  assign term = req ? MASK : '0;
endmodule

module pipe_ctrl_gen #(
  parameter int                     STAGES       = 6,
  parameter int                     NREQ         = 4,
  parameter logic [NREQ*STAGES-1:0] REQ_MASKS    = {6'b111111, 6'b011111, 6'b001111, 6'b000111},
  parameter int                     FLUSH_CYCLES = 2,
  parameter int                     WDOG_LIMIT   = 1024,
  parameter int                     CNT_W        = 32
) (
  input logic           clk,
  input logic           resetn,
  pipe_ctrl_gen_if.slave bus
);
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                       state, state_nx;
  logic [FC_W-1:0]              fcnt, fcnt_nx;
  logic [31:0]                  pc_q, pc_nx;
  logic [NREQ-1:0][STAGES-1:0]  terms;
  logic [STAGES-1:0]            raw;
  logic [STAGES-1:0]            stall;
  logic [CNT_W-1:0]             scnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    pipe_ctrl_req_mask #(
      .STAGES (STAGES),
      .MASK   (REQ_MASKS[i*STAGES +: STAGES])
    ) u_mask (
      .req  (bus.stall_req[i]),
      .term (terms[i])
    );
  end

  // OR all requester terms into the raw stall vector.
  always_comb begin
    raw = '0;
    for (int i = 0; i < NREQ; i++) raw = raw | terms[i];
  end

  // Stalls are suppressed while the pipe is being flushed.
  assign stall = (state == FLUSH) ? '0 : raw;

  // Redirect FSM registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      fcnt  <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
      pc_q  <= pc_nx;
    end
  end

  // Next state: a redirect is only accepted from IDLE; flush length is fixed.
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    pc_nx    = pc_q;
    case (state)
      IDLE: if (bus.excp_req) begin
        state_nx = FLUSH;
        fcnt_nx  = FC_W'(FLUSH_CYCLES - 1);
        pc_nx    = bus.excp_pc;
      end
      FLUSH: begin
        if (fcnt == '0) state_nx = IDLE;
        else            fcnt_nx  = fcnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Saturating count of cycles where the stall output is active; clear wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 scnt <= '0;
    else if (bus.perf_clr)       scnt <= '0;
    else if (|stall && !(&scnt)) scnt <= scnt + 1'b1;
  end

  if (WDOG_LIMIT > 0) begin : g_wdog
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_to;
    logic            wd_act;

    assign wd_act = (state == IDLE) && (|raw);

    // Consecutive-stall counter; timeout is sticky until cleared, clear wins.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        wd_cnt <= '0;
        wd_to  <= 1'b0;
      end else if (bus.wdog_clr) begin
        wd_cnt <= '0;
        wd_to  <= 1'b0;
      end else if (!wd_act) begin
        wd_cnt <= '0;
      end else begin
        if (wd_cnt != WD_W'(WDOG_LIMIT))      wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt >= WD_W'(WDOG_LIMIT - 1)) wd_to  <= 1'b1;
      end
    end

    assign bus.stall_timeout = wd_to;
  end else begin : g_no_wdog
    assign bus.stall_timeout = 1'b0;
  end

  assign bus.stall     = stall;
  assign bus.flush     = (state == FLUSH);
  assign bus.new_pc    = pc_q;
  assign bus.stall_cnt = scnt;
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench: merge table plus flush, watchdog, counter and reset sequences.
// u1: WDOG_LIMIT=8, 32-bit counter.  u2: watchdog disabled, 3-bit counter.
module tb_pipe_ctrl_gen;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  stall_req;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic        wdog_clr;
  logic        perf_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_gen_if #(.STAGES(6), .NREQ(4), .CNT_W(32)) b1 ();
  pipe_ctrl_gen_if #(.STAGES(6), .NREQ(4), .CNT_W(3))  b2 ();

  assign b1.stall_req = stall_req;
  assign b1.excp_req  = excp_req;
  assign b1.excp_pc   = excp_pc;
  assign b1.wdog_clr  = wdog_clr;
  assign b1.perf_clr  = perf_clr;
  assign b2.stall_req = stall_req;
  assign b2.excp_req  = excp_req;
  assign b2.excp_pc   = excp_pc;
  assign b2.wdog_clr  = wdog_clr;
  assign b2.perf_clr  = perf_clr;

  pipe_ctrl_gen #(.WDOG_LIMIT(8), .CNT_W(32)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  pipe_ctrl_gen #(.WDOG_LIMIT(0), .CNT_W(3))  u2 (.clk(clk), .resetn(resetn), .bus(b2));

  typedef struct {
    logic [3:0] req;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b0001, 6'b000111};
    tbl[1] = '{4'b0010, 6'b001111};
    tbl[2] = '{4'b0011, 6'b001111};
    tbl[3] = '{4'b1000, 6'b111111};
    tbl[4] = '{4'b0100, 6'b011111};
    tbl[5] = '{4'b0110, 6'b011111};
    tbl[6] = '{4'b1111, 6'b111111};
    tbl[7] = '{4'b0000, 6'b000000};

    resetn = 1'b0; stall_req = '0; excp_req = 1'b0; excp_pc = '0;
    wdog_clr = 1'b0; perf_clr = 1'b0;
    #12;
    chk("rst_stall",   64'(b1.stall), 64'(0));
    chk("rst_flush",   64'(b1.flush), 64'(0));
    chk("rst_new_pc",  64'(b1.new_pc), 64'(0));
    chk("rst_timeout", 64'(b1.stall_timeout), 64'(0));
    chk("rst_cnt",     64'(b1.stall_cnt), 64'(0));
    resetn = 1'b1;
    tick();

    // Combinational merge table (7 stalled cycles, below watchdog limit).
    for (int i = 0; i < 8; i++) begin
      stall_req = tbl[i].req;
      #1;
      chk($sformatf("merge[%0d]", i), 64'(b1.stall), 64'(tbl[i].exp));
      tick();
    end
    chk("merge_no_timeout", 64'(b1.stall_timeout), 64'(0));

    // Plain redirect: flush for exactly two cycles, registered.
    excp_req = 1'b1; excp_pc = 32'hBFC0_0380;
    #1;
    chk("excp_no_comb_flush", 64'(b1.flush), 64'(0));
    tick();
    excp_req = 1'b0; excp_pc = '0;
    chk("flush_c1",   64'(b1.flush), 64'(1));
    chk("new_pc_c1",  64'(b1.new_pc), 64'(32'hBFC0_0380));
    tick();
    chk("flush_c2",   64'(b1.flush), 64'(1));
    tick();
    chk("flush_end",  64'(b1.flush), 64'(0));
    chk("new_pc_hold",64'(b1.new_pc), 64'(32'hBFC0_0380));

    // Redirect with stall held, second redirect mid-flush ignored.
    stall_req = 4'b0001; excp_req = 1'b1; excp_pc = 32'hBFC0_0380;
    #1;
    chk("excp_stall_req_cyc", 64'(b1.stall), 64'(6'b000111));
    tick();
    excp_pc = 32'h8000_0000;
    chk("fl1_stall", 64'(b1.stall), 64'(0));
    chk("fl1_flush", 64'(b1.flush), 64'(1));
    tick();
    excp_req = 1'b0; excp_pc = '0;
    chk("fl2_stall", 64'(b1.stall), 64'(0));
    chk("fl2_flush", 64'(b1.flush), 64'(1));
    chk("fl2_new_pc", 64'(b1.new_pc), 64'(32'hBFC0_0380));
    tick();
    chk("fl_done_flush", 64'(b1.flush), 64'(0));
    chk("fl_done_stall", 64'(b1.stall), 64'(6'b000111));
    chk("fl_done_new_pc", 64'(b1.new_pc), 64'(32'hBFC0_0380));
    stall_req = '0;
    tick();

    // Watchdog: limit 8 consecutive stalled cycles.
    stall_req = 4'b0010;
    for (int i = 0; i < 7; i++) tick();
    chk("wdog_7", 64'(b1.stall_timeout), 64'(0));
    tick();
    chk("wdog_8", 64'(b1.stall_timeout), 64'(1));
    stall_req = '0;
    tick(); tick();
    chk("wdog_sticky", 64'(b1.stall_timeout), 64'(1));
    chk("wdog_off_u2", 64'(b2.stall_timeout), 64'(0));
    wdog_clr = 1'b1;
    tick();
    wdog_clr = 1'b0;
    chk("wdog_clr", 64'(b1.stall_timeout), 64'(0));

    // Stall-cycle counter.
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr1", 64'(b1.stall_cnt), 64'(0));
    chk("perf_clr1_u2", 64'(b2.stall_cnt), 64'(0));
    stall_req = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    stall_req = '0;
    for (int i = 0; i < 3; i++) tick();
    stall_req = 4'b0100;
    for (int i = 0; i < 2; i++) tick();
    stall_req = '0;
    chk("cnt_7", 64'(b1.stall_cnt), 64'(7));
    stall_req = 4'b0001; perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    chk("perf_clr_wins", 64'(b1.stall_cnt), 64'(0));
    for (int i = 0; i < 10; i++) tick();
    chk("cnt_10", 64'(b1.stall_cnt), 64'(10));
    chk("cnt_sat_u2", 64'(b2.stall_cnt), 64'(7));
    stall_req = '0;
    tick();

    // Reset during first flush cycle.
    excp_req = 1'b1; excp_pc = 32'hBFC0_0380;
    tick();
    excp_req = 1'b0; excp_pc = '0;
    chk("pre_rst_flush", 64'(b1.flush), 64'(1));
    #1 resetn = 1'b0;
    #1;
    chk("async_rst_flush",  64'(b1.flush), 64'(0));
    chk("async_rst_new_pc", 64'(b1.new_pc), 64'(0));
    chk("async_rst_cnt",    64'(b1.stall_cnt), 64'(0));
    #2 resetn = 1'b1;
    tick(); tick();
    chk("post_rst_flush",   64'(b1.flush), 64'(0));
    chk("post_rst_stall",   64'(b1.stall), 64'(0));
    chk("post_rst_new_pc",  64'(b1.new_pc), 64'(0));
    chk("post_rst_cnt",     64'(b1.stall_cnt), 64'(0));
    chk("post_rst_timeout", 64'(b1.stall_timeout), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
